// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: sequential fetch, absolute/relative/conditional branches,
// CALL/RET through an internal return-address stack, stall, and halt/resume.
// Stack overflow/underflow halts the core and sets a sticky error that only reset clears.
module pc_seq_unit #(
    parameter int unsigned    D           = 12,
    parameter int unsigned    OFF_W       = 8,
    parameter int unsigned    STACK_DEPTH = 4,
    parameter logic [D-1:0]   START_ADDR  = '0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               stall,
    input  logic [2:0]                         pc_op,
    input  logic                               cond,
    input  logic [D-1:0]                       target,
    input  logic [OFF_W-1:0]                   offset,
    input  logic                               resume,
    output logic [D-1:0]                       prog_ctr,
    output logic                               halted,
    output logic                               stack_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_JABS = 3'b001;
    localparam logic [2:0] OP_JREL = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [D-1:0]       r_pc;
    logic [D-1:0]       w_pc_nxt;
    logic [SP_W-1:0]    r_sp;
    logic [SP_W-1:0]    w_sp_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_halted;
    logic [D-1:0]       r_stack [STACK_DEPTH];

    logic               w_push;
    logic [IDX_W-1:0]   w_push_idx;
    logic [IDX_W-1:0]   w_pop_idx;
    logic [D-1:0]       w_pc_inc;
    logic [D-1:0]       w_pc_rel;
    logic [D-1:0]       w_off_sext;

    // Address arithmetic, all modulo 2^D; offset is sign-extended before the add
    assign w_pc_inc   = r_pc + D'(1);
    assign w_off_sext = D'($signed(offset));
    assign w_pc_rel   = r_pc + w_off_sext;
    assign w_push_idx = IDX_W'(r_sp);
    assign w_pop_idx  = IDX_W'(r_sp - SP_ONE);

    // Next-state / next-value decode for RUN and HALT
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sp_nxt    = r_sp;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    case (pc_op)
                        OP_JABS: w_pc_nxt = cond ? target : w_pc_inc;
                        OP_JREL: w_pc_nxt = cond ? w_pc_rel : w_pc_inc;
                        OP_CALL: begin
                            if (r_sp < SP_FULL) begin
                                w_push   = 1'b1;
                                w_sp_nxt = r_sp + SP_ONE;
                                w_pc_nxt = target;
                            end else begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = ST_HALT;
                            end
                        end
                        OP_RET: begin
                            if (r_sp != '0) begin
                                w_sp_nxt = r_sp - SP_ONE;
                                w_pc_nxt = r_stack[w_pop_idx];
                            end else begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = ST_HALT;
                            end
                        end
                        OP_HALT: w_state_nxt = ST_HALT;
                        default: w_pc_nxt = w_pc_inc;
                    endcase
                end
            end
            ST_HALT: begin
                if (resume && !r_err) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = w_pc_inc;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_pc     <= START_ADDR;
            r_sp     <= '0;
            r_err    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_sp     <= w_sp_nxt;
            r_err    <= w_err_nxt;
            r_halted <= (w_state_nxt == ST_HALT);
        end
    end

    // Return-address storage; a push coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign prog_ctr  = r_pc;
    assign sp        = r_sp;
    assign stack_err = r_err;
    assign halted    = r_halted;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: per-feature vector tables with hand-computed expectations.
module tb_pc_seq_unit;

    localparam logic [2:0] SEQ  = 3'b000;
    localparam logic [2:0] JABS = 3'b001;
    localparam logic [2:0] JREL = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;
    localparam logic [2:0] HALT = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  pc_op = SEQ;
    logic        cond = 1'b0;
    logic [11:0] target = '0;
    logic [7:0]  offset = '0;
    logic        resume = 1'b0;
    logic [11:0] prog_ctr;
    logic        halted;
    logic        stack_err;
    logic [2:0]  sp;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        stl;
        logic [2:0]  op;
        logic        cnd;
        logic [11:0] tgt;
        logic [7:0]  off;
        logic        res;
        logic [11:0] e_pc;
        logic [2:0]  e_sp;
        logic        e_h;
        logic        e_e;
    } vec_t;

    pc_seq_unit #(
        .D(12), .OFF_W(8), .STACK_DEPTH(4), .START_ADDR(12'h000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .pc_op(pc_op), .cond(cond),
        .target(target), .offset(offset), .resume(resume), .prog_ctr(prog_ctr),
        .halted(halted), .stack_err(stack_err), .sp(sp)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic stl, input logic [2:0] op,
                                input logic cnd, input logic [11:0] tgt, input logic [7:0] off,
                                input logic res, input logic [11:0] e_pc, input logic [2:0] e_sp,
                                input logic e_h, input logic e_e);
        vec_t v;
        v.rst = rst; v.stl = stl; v.op = op; v.cnd = cnd; v.tgt = tgt; v.off = off;
        v.res = res; v.e_pc = e_pc; v.e_sp = e_sp; v.e_h = e_h; v.e_e = e_e;
        return v;
    endfunction

    task automatic test_reset();
        vec_t v[$];
        v.push_back(mk(0, 0, SEQ,    0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(0, 1, JABS,   1, 12'h555, 8'h00, 1, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, SEQ,    0, 12'h000, 8'h00, 0, 12'h001, 3'd0, 0, 0));
        v.push_back(mk(1, 0, SEQ,    0, 12'h000, 8'h00, 0, 12'h002, 3'd0, 0, 0));
        v.push_back(mk(1, 0, SEQ,    0, 12'h000, 8'h00, 0, 12'h003, 3'd0, 0, 0));
        v.push_back(mk(1, 0, 3'b110, 1, 12'h777, 8'h00, 0, 12'h004, 3'd0, 0, 0));
        v.push_back(mk(1, 0, 3'b111, 1, 12'h777, 8'h00, 0, 12'h005, 3'd0, 0, 0));
        foreach (v[i]) begin
            reset_n = v[i].rst; stall = v[i].stl; pc_op = v[i].op; cond = v[i].cnd;
            target = v[i].tgt; offset = v[i].off; resume = v[i].res;
            @(posedge clk); #1;
            total++;
            if ({prog_ctr, sp, halted, stack_err} !== {v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e}) begin
                bad++;
                $display("FAIL reset[%0d]: pc=%h sp=%0d halted=%b err=%b, expected pc=%h sp=%0d halted=%b err=%b",
                         i, prog_ctr, sp, halted, stack_err, v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e);
            end
        end
    endtask

    task automatic test_branch_wrap();
        vec_t v[$];
        v.push_back(mk(1, 0, JABS, 1, 12'hFFE, 8'h00, 0, 12'hFFE, 3'd0, 0, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'hFFF, 3'd0, 0, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JABS, 1, 12'h002, 8'h00, 0, 12'h002, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JREL, 1, 12'h000, 8'hFC, 0, 12'hFFE, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JABS, 1, 12'h002, 8'h00, 0, 12'h002, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JREL, 0, 12'h000, 8'hFC, 0, 12'h003, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JABS, 0, 12'h777, 8'h00, 0, 12'h004, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JREL, 1, 12'h000, 8'h05, 0, 12'h009, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JREL, 1, 12'h000, 8'h7F, 0, 12'h088, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JABS, 1, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JREL, 1, 12'h000, 8'hFF, 0, 12'hFFF, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JREL, 1, 12'h000, 8'h80, 0, 12'hF7F, 3'd0, 0, 0));
        foreach (v[i]) begin
            reset_n = v[i].rst; stall = v[i].stl; pc_op = v[i].op; cond = v[i].cnd;
            target = v[i].tgt; offset = v[i].off; resume = v[i].res;
            @(posedge clk); #1;
            total++;
            if ({prog_ctr, sp, halted, stack_err} !== {v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e}) begin
                bad++;
                $display("FAIL branch_wrap[%0d]: pc=%h sp=%0d halted=%b err=%b, expected pc=%h sp=%0d halted=%b err=%b",
                         i, prog_ctr, sp, halted, stack_err, v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e);
            end
        end
    endtask

    task automatic test_call_ret();
        vec_t v[$];
        v.push_back(mk(0, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JABS, 1, 12'h010, 8'h00, 0, 12'h010, 3'd0, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h100, 8'h00, 0, 12'h100, 3'd1, 0, 0));
        v.push_back(mk(1, 0, CALL, 1, 12'h200, 8'h00, 0, 12'h200, 3'd2, 0, 0));
        v.push_back(mk(1, 0, RET,  0, 12'h000, 8'h00, 0, 12'h101, 3'd1, 0, 0));
        v.push_back(mk(1, 0, RET,  1, 12'h000, 8'h00, 0, 12'h011, 3'd0, 0, 0));
        v.push_back(mk(1, 0, CALL, 1, 12'h300, 8'h00, 0, 12'h300, 3'd1, 0, 0));
        v.push_back(mk(1, 0, RET,  0, 12'h000, 8'h00, 0, 12'h012, 3'd0, 0, 0));
        foreach (v[i]) begin
            reset_n = v[i].rst; stall = v[i].stl; pc_op = v[i].op; cond = v[i].cnd;
            target = v[i].tgt; offset = v[i].off; resume = v[i].res;
            @(posedge clk); #1;
            total++;
            if ({prog_ctr, sp, halted, stack_err} !== {v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e}) begin
                bad++;
                $display("FAIL call_ret[%0d]: pc=%h sp=%0d halted=%b err=%b, expected pc=%h sp=%0d halted=%b err=%b",
                         i, prog_ctr, sp, halted, stack_err, v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e);
            end
        end
    endtask

    task automatic test_full_lifo();
        vec_t v[$];
        v.push_back(mk(0, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h010, 8'h00, 0, 12'h010, 3'd1, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h020, 8'h00, 0, 12'h020, 3'd2, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h030, 8'h00, 0, 12'h030, 3'd3, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h040, 8'h00, 0, 12'h040, 3'd4, 0, 0));
        v.push_back(mk(1, 0, RET,  0, 12'h000, 8'h00, 0, 12'h031, 3'd3, 0, 0));
        v.push_back(mk(1, 0, RET,  0, 12'h000, 8'h00, 0, 12'h021, 3'd2, 0, 0));
        v.push_back(mk(1, 0, RET,  0, 12'h000, 8'h00, 0, 12'h011, 3'd1, 0, 0));
        v.push_back(mk(1, 0, RET,  0, 12'h000, 8'h00, 0, 12'h001, 3'd0, 0, 0));
        foreach (v[i]) begin
            reset_n = v[i].rst; stall = v[i].stl; pc_op = v[i].op; cond = v[i].cnd;
            target = v[i].tgt; offset = v[i].off; resume = v[i].res;
            @(posedge clk); #1;
            total++;
            if ({prog_ctr, sp, halted, stack_err} !== {v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e}) begin
                bad++;
                $display("FAIL full_lifo[%0d]: pc=%h sp=%0d halted=%b err=%b, expected pc=%h sp=%0d halted=%b err=%b",
                         i, prog_ctr, sp, halted, stack_err, v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e);
            end
        end
    endtask

    task automatic test_stack_fault();
        vec_t v[$];
        v.push_back(mk(0, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h010, 8'h00, 0, 12'h010, 3'd1, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h020, 8'h00, 0, 12'h020, 3'd2, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h030, 8'h00, 0, 12'h030, 3'd3, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h040, 8'h00, 0, 12'h040, 3'd4, 0, 0));
        v.push_back(mk(1, 0, CALL, 0, 12'h050, 8'h00, 0, 12'h040, 3'd4, 1, 1));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 1, 12'h040, 3'd4, 1, 1));
        v.push_back(mk(1, 0, RET,  0, 12'h000, 8'h00, 1, 12'h040, 3'd4, 1, 1));
        v.push_back(mk(0, 0, CALL, 0, 12'h060, 8'h00, 1, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, RET,  0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 1, 1));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 1, 12'h000, 3'd0, 1, 1));
        v.push_back(mk(0, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h001, 3'd0, 0, 0));
        foreach (v[i]) begin
            reset_n = v[i].rst; stall = v[i].stl; pc_op = v[i].op; cond = v[i].cnd;
            target = v[i].tgt; offset = v[i].off; resume = v[i].res;
            @(posedge clk); #1;
            total++;
            if ({prog_ctr, sp, halted, stack_err} !== {v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e}) begin
                bad++;
                $display("FAIL stack_fault[%0d]: pc=%h sp=%0d halted=%b err=%b, expected pc=%h sp=%0d halted=%b err=%b",
                         i, prog_ctr, sp, halted, stack_err, v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e);
            end
        end
    endtask

    task automatic test_stall();
        vec_t v[$];
        v.push_back(mk(0, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h001, 3'd0, 0, 0));
        v.push_back(mk(1, 1, JABS, 1, 12'h055, 8'h00, 0, 12'h001, 3'd0, 0, 0));
        v.push_back(mk(1, 1, CALL, 1, 12'h0AA, 8'h00, 0, 12'h001, 3'd0, 0, 0));
        v.push_back(mk(1, 1, HALT, 0, 12'h000, 8'h00, 0, 12'h001, 3'd0, 0, 0));
        v.push_back(mk(1, 1, RET,  0, 12'h000, 8'h00, 0, 12'h001, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JABS, 1, 12'h055, 8'h00, 0, 12'h055, 3'd0, 0, 0));
        foreach (v[i]) begin
            reset_n = v[i].rst; stall = v[i].stl; pc_op = v[i].op; cond = v[i].cnd;
            target = v[i].tgt; offset = v[i].off; resume = v[i].res;
            @(posedge clk); #1;
            total++;
            if ({prog_ctr, sp, halted, stack_err} !== {v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e}) begin
                bad++;
                $display("FAIL stall[%0d]: pc=%h sp=%0d halted=%b err=%b, expected pc=%h sp=%0d halted=%b err=%b",
                         i, prog_ctr, sp, halted, stack_err, v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e);
            end
        end
    endtask

    task automatic test_halt_resume();
        vec_t v[$];
        v.push_back(mk(0, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        v.push_back(mk(1, 0, JABS, 1, 12'h020, 8'h00, 0, 12'h020, 3'd0, 0, 0));
        v.push_back(mk(1, 0, HALT, 0, 12'h000, 8'h00, 0, 12'h020, 3'd0, 1, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h020, 3'd0, 1, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h020, 3'd0, 1, 0));
        v.push_back(mk(1, 0, CALL, 1, 12'h300, 8'h00, 0, 12'h020, 3'd0, 1, 0));
        v.push_back(mk(1, 1, JABS, 1, 12'h300, 8'h00, 0, 12'h020, 3'd0, 1, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h020, 3'd0, 1, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 1, 12'h021, 3'd0, 0, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h022, 3'd0, 0, 0));
        v.push_back(mk(1, 0, HALT, 0, 12'h000, 8'h00, 1, 12'h022, 3'd0, 1, 0));
        v.push_back(mk(1, 0, SEQ,  0, 12'h000, 8'h00, 1, 12'h023, 3'd0, 0, 0));
        v.push_back(mk(1, 0, HALT, 0, 12'h000, 8'h00, 0, 12'h023, 3'd0, 1, 0));
        v.push_back(mk(0, 0, SEQ,  0, 12'h000, 8'h00, 0, 12'h000, 3'd0, 0, 0));
        foreach (v[i]) begin
            reset_n = v[i].rst; stall = v[i].stl; pc_op = v[i].op; cond = v[i].cnd;
            target = v[i].tgt; offset = v[i].off; resume = v[i].res;
            @(posedge clk); #1;
            total++;
            if ({prog_ctr, sp, halted, stack_err} !== {v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e}) begin
                bad++;
                $display("FAIL halt_resume[%0d]: pc=%h sp=%0d halted=%b err=%b, expected pc=%h sp=%0d halted=%b err=%b",
                         i, prog_ctr, sp, halted, stack_err, v[i].e_pc, v[i].e_sp, v[i].e_h, v[i].e_e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch_wrap();
        test_call_ret();
        test_full_lifo();
        test_stack_fault();
        test_stall();
        test_halt_resume();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
